// File: rtl/mem_stage.sv
// MEM pipeline stage: takes EX results and data-SRAM responses, aligns load data and hands the
// registered payload to WB. Bus layouts are the concatenation of their listed fields, MSB first.
module mem_stage #(
    parameter int unsigned PC_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [PC_W-1:0]   es_pc,
    input  logic [PC_W-1:0]   es_result,
    input  logic [PC_W-1:0]   es_rt_value,
    input  logic              es_gr_we,
    input  logic [4:0]        es_dest,
    input  logic              es_mem_req,
    input  logic [2:0]        es_ld_op,
    input  logic              es_excp_valid,
    input  logic [4:0]        es_excp_code,
    input  logic              es_bd,
    input  logic [10:0]       es_cp0_ctl,
    input  logic              data_sram_data_ok,
    input  logic [PC_W-1:0]   data_sram_rdata,
    input  logic              flush,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [3*PC_W+23:0] ms_to_ws_bus,
    output logic [PC_W+7:0]   ms_fw_bus
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] result;
        logic [PC_W-1:0] rt_value;
        logic            gr_we;
        logic [4:0]      dest;
        logic            mem_req;
        logic [2:0]      ld_op;
        logic            excp_valid;
        logic [4:0]      excp_code;
        logic            bd;
        logic [10:0]     cp0_ctl;
    } payload_t;

    localparam logic [2:0] OpLw  = 3'd0;
    localparam logic [2:0] OpLb  = 3'd1;
    localparam logic [2:0] OpLbu = 3'd2;
    localparam logic [2:0] OpLh  = 3'd3;
    localparam logic [2:0] OpLhu = 3'd4;
    localparam logic [2:0] OpLwl = 3'd5;
    localparam logic [2:0] OpLwr = 3'd6;

    payload_t        payload_q, payload_d;
    logic            ms_valid_q, ms_valid_d;
    logic            data_buf_valid_q, data_buf_valid_d;
    logic [PC_W-1:0] data_buf_q, data_buf_d;
    logic            discard_pending_q, discard_pending_d;

    logic            data_ok_live;
    logic            ms_ready_go;
    logic            blocked;
    logic [PC_W-1:0] ld_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [PC_W-1:0] aligned;
    logic [PC_W-1:0] final_result;
    logic [1:0]      addr_lo;

    // A response owed to a flushed load is not ours to consume.
    assign data_ok_live   = data_sram_data_ok && !discard_pending_q;
    assign ms_ready_go    = !payload_q.mem_req || data_buf_valid_q || data_ok_live;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    // MFC0 data only exists in WB, so consumers must stall rather than forward.
    assign blocked        = ms_valid_q &&
                            ((payload_q.mem_req && !ms_ready_go) || payload_q.cp0_ctl[8]);

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        payload_d = payload_q;
        if (es_to_ms_valid && ms_allowin) begin
            payload_d.pc         = es_pc;
            payload_d.result     = es_result;
            payload_d.rt_value   = es_rt_value;
            payload_d.gr_we      = es_gr_we;
            payload_d.dest       = es_dest;
            payload_d.mem_req    = es_mem_req;
            payload_d.ld_op      = es_ld_op;
            payload_d.excp_valid = es_excp_valid;
            payload_d.excp_code  = es_excp_code;
            payload_d.bd         = es_bd;
            payload_d.cp0_ctl    = es_cp0_ctl;
        end
    end

    always_comb begin
        data_buf_valid_d = data_buf_valid_q;
        data_buf_d       = data_buf_q;
        if (flush || (ms_to_ws_valid && ws_allowin)) begin
            data_buf_valid_d = 1'b0;
        end else if (data_ok_live && ms_valid_q && payload_q.mem_req && !data_buf_valid_q &&
                     !ws_allowin) begin
            data_buf_valid_d = 1'b1;
            data_buf_d       = data_sram_rdata;
        end

        discard_pending_d = discard_pending_q;
        if (flush && ms_valid_q && payload_q.mem_req && !data_buf_valid_q && !data_ok_live) begin
            discard_pending_d = 1'b1;
        end else if (data_sram_data_ok) begin
            discard_pending_d = 1'b0;
        end
    end

    always_comb begin
        addr_lo = payload_q.result[1:0];
        ld_word = data_buf_valid_q ? data_buf_q : data_sram_rdata;
        ld_byte = ld_word[7:0];
        unique case (addr_lo)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        aligned = ld_word;
        case (payload_q.ld_op)
            OpLw:  aligned = ld_word;
            OpLb:  aligned = {{(PC_W-8){ld_byte[7]}}, ld_byte};
            OpLbu: aligned = {{(PC_W-8){1'b0}}, ld_byte};
            OpLh:  aligned = {{(PC_W-16){ld_half[15]}}, ld_half};
            OpLhu: aligned = {{(PC_W-16){1'b0}}, ld_half};
            OpLwl: begin
                unique case (addr_lo)
                    2'd0: aligned = {ld_word[7:0], payload_q.rt_value[23:0]};
                    2'd1: aligned = {ld_word[15:0], payload_q.rt_value[15:0]};
                    2'd2: aligned = {ld_word[23:0], payload_q.rt_value[7:0]};
                    default: aligned = ld_word;
                endcase
            end
            OpLwr: begin
                unique case (addr_lo)
                    2'd1: aligned = {payload_q.rt_value[31:24], ld_word[31:8]};
                    2'd2: aligned = {payload_q.rt_value[31:16], ld_word[31:16]};
                    2'd3: aligned = {payload_q.rt_value[31:8], ld_word[31:24]};
                    default: aligned = ld_word;
                endcase
            end
            default: aligned = ld_word;
        endcase

        final_result = payload_q.mem_req ? aligned : payload_q.result;
    end

    assign ms_to_ws_bus = {payload_q.bd, payload_q.rt_value, payload_q.cp0_ctl,
                           payload_q.excp_valid, payload_q.excp_code, payload_q.gr_we,
                           payload_q.dest, final_result, payload_q.pc};
    assign ms_fw_bus    = {ms_valid_q, blocked, payload_q.gr_we && ms_valid_q, payload_q.dest,
                           final_result};

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q        <= 1'b0;
            payload_q         <= '0;
            data_buf_valid_q  <= 1'b0;
            data_buf_q        <= '0;
            discard_pending_q <= 1'b0;
        end else begin
            ms_valid_q        <= ms_valid_d;
            payload_q         <= payload_d;
            data_buf_valid_q  <= data_buf_valid_d;
            data_buf_q        <= data_buf_d;
            discard_pending_q <= discard_pending_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage; expected WB payloads come from a byte-lane
// arithmetic model of the load rules.
module tb_mem_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] rt;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_req;
        logic [2:0]  ld_op;
        logic        ev;
        logic [4:0]  ec;
        logic        bd;
        logic [10:0] cp0;
    } instr_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid;
    logic         ms_allowin;
    logic [31:0]  es_pc, es_result, es_rt_value;
    logic         es_gr_we;
    logic [4:0]   es_dest;
    logic         es_mem_req;
    logic [2:0]   es_ld_op;
    logic         es_excp_valid;
    logic [4:0]   es_excp_code;
    logic         es_bd;
    logic [10:0]  es_cp0_ctl;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         flush;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [119:0] ms_to_ws_bus;
    logic [39:0]  ms_fw_bus;

    int checks = 0;
    int errors = 0;

    mem_stage #(.PC_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_rt_value       (es_rt_value),
        .es_gr_we          (es_gr_we),
        .es_dest           (es_dest),
        .es_mem_req        (es_mem_req),
        .es_ld_op          (es_ld_op),
        .es_excp_valid     (es_excp_valid),
        .es_excp_code      (es_excp_code),
        .es_bd             (es_bd),
        .es_cp0_ctl        (es_cp0_ctl),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_fw_bus         (ms_fw_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load result built from shifts and lane masks rather than per-case slices.
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] r, input logic [31:0] t);
        logic [31:0] b, h;
        int sh;
        b = (r >> (8 * int'(a))) & 32'hFF;
        h = (r >> (16 * int'(a[1]))) & 32'hFFFF;
        case (op)
            3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd2: return b;
            3'd3: return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4: return h;
            3'd5: begin
                sh = 8 * (3 - int'(a));
                return (r << sh) | (t & ~(32'hFFFF_FFFF << sh));
            end
            3'd6: begin
                sh = 8 * int'(a);
                return (r >> sh) | (t & ~(32'hFFFF_FFFF >> sh));
            end
            default: return r;
        endcase
    endfunction

    function automatic instr_t mk(input logic [31:0] result, input logic [31:0] rt,
                                  input logic mem_req, input logic [2:0] op);
        instr_t i;
        i.pc = 32'hBFC0_0100; i.result = result; i.rt = rt; i.gr_we = 1'b1; i.dest = 5'd7;
        i.mem_req = mem_req; i.ld_op = op; i.ev = 1'b0; i.ec = 5'd0; i.bd = 1'b0;
        i.cp0 = 11'd0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.pc = $urandom; i.result = $urandom; i.rt = $urandom;
        i.gr_we = 1'($urandom); i.dest = 5'($urandom); i.ld_op = 3'($urandom_range(0, 6));
        i.ev = ($urandom_range(0, 7) == 0); i.ec = 5'($urandom); i.bd = 1'($urandom);
        i.cp0 = 11'($urandom);
        i.mem_req = !i.ev && ($urandom_range(0, 1) == 1);
        return i;
    endfunction

    task automatic drive_es(input instr_t i);
        es_to_ms_valid = 1'b1; es_pc = i.pc; es_result = i.result; es_rt_value = i.rt;
        es_gr_we = i.gr_we; es_dest = i.dest; es_mem_req = i.mem_req; es_ld_op = i.ld_op;
        es_excp_valid = i.ev; es_excp_code = i.ec; es_bd = i.bd; es_cp0_ctl = i.cp0;
    endtask

    // Runs one instruction alone through MS: entry, ok_delay empty response cycles (loads),
    // data_ok carrying rd, stall cycles with ws_allowin low, handoff, then an empty cycle.
    task automatic do_instr(input string tag, input instr_t in, input int ok_delay,
                            input int stall, input logic [31:0] rd, input logic [31:0] fin);
        logic [119:0] eb;
        logic [39:0]  efw;
        eb  = {in.bd, in.rt, in.cp0, in.ev, in.ec, in.gr_we, in.dest, fin, in.pc};
        efw = {1'b1, in.cp0[8], in.gr_we, in.dest, fin};
        drive_es(in);
        flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        ws_allowin = 1'($urandom);
        #3;
        chk({tag, "/entry_allowin"}, ms_allowin, 1'b1);
        chk({tag, "/entry_valid"}, ms_to_ws_valid, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        if (in.mem_req) begin
            for (int k = 0; k < ok_delay; k++) begin
                ws_allowin = 1'($urandom); data_sram_rdata = $urandom;
                #3;
                chk({tag, "/wait_valid"}, ms_to_ws_valid, 1'b0);
                chk({tag, "/wait_blocked"}, ms_fw_bus[38], 1'b1);
                chk({tag, "/wait_allowin"}, ms_allowin, 1'b0);
                tick();
            end
            data_sram_data_ok = 1'b1; data_sram_rdata = rd;
        end
        for (int k = 0; k < stall; k++) begin
            ws_allowin = 1'b0;
            #3;
            chk({tag, "/stall_valid"}, ms_to_ws_valid, 1'b1);
            chk({tag, "/stall_bus"}, ms_to_ws_bus, eb);
            chk({tag, "/stall_allowin"}, ms_allowin, 1'b0);
            tick();
            data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        end
        ws_allowin = 1'b1;
        #3;
        chk({tag, "/deliver_valid"}, ms_to_ws_valid, 1'b1);
        chk({tag, "/deliver_bus"}, ms_to_ws_bus, eb);
        chk({tag, "/deliver_fw"}, ms_fw_bus, efw);
        chk({tag, "/deliver_allowin"}, ms_allowin, 1'b1);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        #3;
        chk({tag, "/drained"}, ms_fw_bus[39], 1'b0);
        tick();
    endtask

    initial begin
        instr_t i;
        logic [31:0] rd;

        reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        drive_es(mk(32'h0, 32'h0, 1'b0, 3'd0));
        es_to_ms_valid = 1'b0;
        tick(); tick();
        chk("reset_valid", ms_to_ws_valid, 1'b0);
        chk("reset_bus", ms_to_ws_bus, 120'd0);
        chk("reset_fw", ms_fw_bus, 40'd0);
        reset = 1'b0;
        tick();

        // Sign/zero extension of byte 2 of 0x11803344.
        do_instr("lb", mk(32'h1000_0002, 32'h0, 1'b1, 3'd1), 0, 0, 32'h1180_3344,
                 32'hFFFF_FF80);
        do_instr("lbu", mk(32'h1000_0002, 32'h0, 1'b1, 3'd2), 0, 0, 32'h1180_3344,
                 32'h0000_0080);
        do_instr("lwl", mk(32'h1000_0001, 32'h1122_3344, 1'b1, 3'd5), 1, 0, 32'hAABB_CCDD,
                 32'hCCDD_3344);
        do_instr("lwr", mk(32'h1000_0002, 32'h1122_3344, 1'b1, 3'd6), 2, 0, 32'hAABB_CCDD,
                 32'h1122_AABB);
        // Response buffered across a three-cycle WB stall; the next load must wait again.
        do_instr("buffered", mk(32'h2000_0000, 32'h0, 1'b1, 3'd0), 0, 3, 32'h1234_5678,
                 32'h1234_5678);
        do_instr("after_buf", mk(32'h2000_0004, 32'h0, 1'b1, 3'd3), 2, 0, 32'h8001_7FFF,
                 32'h0000_7FFF);

        // Flush while a load is waiting: its response must be dropped later.
        drive_es(mk(32'h3000_0000, 32'h0, 1'b1, 3'd0));
        tick();
        es_to_ms_valid = 1'b0; flush = 1'b1;
        #3;
        chk("flush_valid", ms_to_ws_valid, 1'b0);
        tick();
        flush = 1'b0;
        drive_es(mk(32'h0000_0005, 32'h0, 1'b0, 3'd0));
        #3;
        chk("flush_killed", ms_fw_bus[39], 1'b0);
        chk("flush_allowin", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        #3;
        chk("alu_after_flush_valid", ms_to_ws_valid, 1'b1);
        chk("alu_after_flush_result", ms_fw_bus[31:0], 32'h5);
        tick();
        drive_es(mk(32'h3000_0008, 32'h0, 1'b1, 3'd0));
        tick();
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_0001;
        #3;
        chk("stale_dropped", ms_to_ws_valid, 1'b0);
        chk("stale_blocked", ms_fw_bus[38], 1'b1);
        tick();
        data_sram_rdata = 32'h0BEE_F002;
        #3;
        chk("second_ok_valid", ms_to_ws_valid, 1'b1);
        chk("second_ok_data", ms_fw_bus[31:0], 32'h0BEE_F002);
        tick();
        data_sram_data_ok = 1'b0;
        #3;
        chk("discard_drained", ms_fw_bus[39], 1'b0);
        tick();

        // Flush in the same cycle as the response: nothing delivered, nothing discarded.
        drive_es(mk(32'h4000_0000, 32'h0, 1'b1, 3'd0));
        tick();
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
        flush = 1'b1;
        #3;
        chk("coinc_no_deliver", ms_to_ws_valid, 1'b0);
        tick();
        flush = 1'b0; data_sram_data_ok = 1'b0;
        #3;
        chk("coinc_empty", ms_fw_bus[39], 1'b0);
        tick();
        do_instr("coinc_next", mk(32'h4000_0003, 32'h0, 1'b1, 3'd2), 0, 0, 32'h9A00_0000,
                 32'h0000_009A);

        // Reset with the response buffer full.
        drive_es(mk(32'h5000_0000, 32'h0, 1'b1, 3'd0));
        tick();
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_0000;
        ws_allowin = 1'b0;
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        #3;
        chk("rst_buf_valid", ms_to_ws_valid, 1'b1);
        chk("rst_buf_data", ms_fw_bus[31:0], 32'h7777_0000);
        reset = 1'b1;
        tick();
        chk("rst_mid_valid", ms_to_ws_valid, 1'b0);
        chk("rst_mid_bus", ms_to_ws_bus, 120'd0);
        chk("rst_mid_fw", ms_fw_bus, 40'd0);
        chk("rst_mid_allowin", ms_allowin, 1'b1);
        reset = 1'b0; ws_allowin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_no_stale", ms_to_ws_valid, 1'b0);
        end
        tick();

        for (int n = 0; n < 60; n++) begin
            i  = rand_instr();
            rd = $urandom;
            do_instr("rand", i, $urandom_range(0, 3), $urandom_range(0, 3), rd,
                     i.mem_req ? model_load(i.ld_op, i.result[1:0], rd, i.rt) : i.result);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
